// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller is the master: it consumes opcode, ALU flags and the memory handshake and drives every select and strobe.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       input_opcode;
  logic             input_Zero;
  logic             input_negative;
  logic             input_mem_ready;
  logic             output_ALUSrcA;
  logic [1:0]       output_ALUSrcB;
  logic [2:0]       output_ALUOp;
  logic             output_PCWrite;
  logic [1:0]       output_PCSrc;
  logic             output_IorD;
  logic             output_MemRead;
  logic             output_MemWrite;
  logic             output_IRWrite;
  logic             output_RegWrite;
  logic             output_RegDst;
  logic             output_MemtoReg;
  logic             output_illegal;
  logic             output_fault;
  logic             output_halted;
  logic [CNT_W-1:0] output_retired;

  modport master (
    input  input_opcode, input_Zero, input_negative, input_mem_ready,
    output output_ALUSrcA, output_ALUSrcB, output_ALUOp, output_PCWrite, output_PCSrc,
    output output_IorD, output_MemRead, output_MemWrite, output_IRWrite, output_RegWrite,
    output output_RegDst, output_MemtoReg, output_illegal, output_fault, output_halted,
    output output_retired
  );

  modport slave (
    output input_opcode, input_Zero, input_negative, input_mem_ready,
    input  output_ALUSrcA, output_ALUSrcB, output_ALUOp, output_PCWrite, output_PCSrc,
    input  output_IorD, output_MemRead, output_MemWrite, output_IRWrite, output_RegWrite,
    input  output_RegDst, output_MemtoReg, output_illegal, output_fault, output_halted,
    input  output_retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multi-cycle processor: fetch/decode/execute/memory/writeback
// sequencing, retired-instruction counting and memory-timeout detection.
module multicycle_control #(
  parameter int CNT_W        = 16,
  parameter int MEM_WAIT_MAX = 255
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);
  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BLT  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_TWO   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  retired_q;
  logic              fault_q;
  logic              regdst_q;
  logic              waiting;
  logic              wait_expired;
  logic              retire;

  // Only FETCH, MEM_RD and MEM_WR wait on memory; leaving or never entering them keeps the counter at zero.
  assign waiting      = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_expired = waiting && !bus.input_mem_ready && (wait_cnt_q == WAIT_LAST);
  assign retire       = (state_q inside {S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP}) ||
                        ((state_q == S_MEM_WR) && bus.input_mem_ready);

  assign bus.output_fault   = fault_q;
  assign bus.output_retired = retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      retired_q  <= '0;
      fault_q    <= 1'b0;
      regdst_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
      state_q    <= state_d;
      wait_cnt_q <= (waiting && !bus.input_mem_ready) ? wait_cnt_q + WAIT_W'(1) : '0;
      if (retire)       retired_q <= retired_q + CNT_W'(1);
      if (wait_expired) fault_q   <= 1'b1;
      // R-type writes rd, ADDI writes rt; the choice is remembered until ALU_WB.
      if (state_q == S_EXEC_R)      regdst_q <= 1'b1;
      else if (state_q == S_EXEC_I) regdst_q <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: every output and the next state get a default first so no branch of the case infers a latch.
    state_d             = state_q;
    bus.output_ALUSrcA  = 1'b0;
    bus.output_ALUSrcB  = SRCB_B;
    bus.output_ALUOp    = ALU_ADD;
    bus.output_PCWrite  = 1'b0;
    bus.output_PCSrc    = 2'b00;
    bus.output_IorD     = 1'b0;
    bus.output_MemRead  = 1'b0;
    bus.output_MemWrite = 1'b0;
    bus.output_IRWrite  = 1'b0;
    bus.output_RegWrite = 1'b0;
    bus.output_RegDst   = 1'b0;
    bus.output_MemtoReg = 1'b0;
    bus.output_illegal  = 1'b0;
    bus.output_halted   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.output_MemRead = 1'b1;
        bus.output_IRWrite = 1'b1;
        bus.output_ALUSrcB = SRCB_TWO;
        if (bus.input_mem_ready) begin
          bus.output_PCWrite = 1'b1;
          state_d            = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        bus.output_ALUSrcB = SRCB_IMMSH;
        case (bus.input_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
          OP_ADDI:                       state_d = S_EXEC_I;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BLT:                state_d = S_BRANCH;
          OP_JMP:                        state_d = S_JUMP;
          OP_HALT:                       state_d = S_HALT;
          default: begin
            bus.output_illegal = 1'b1;
            state_d            = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        bus.output_ALUSrcA = 1'b1;
        bus.output_ALUOp   = bus.input_opcode[2:0];
        state_d            = S_ALU_WB;
      end
      S_EXEC_I: begin
        bus.output_ALUSrcA = 1'b1;
        bus.output_ALUSrcB = SRCB_IMM;
        state_d            = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.output_RegWrite = 1'b1;
        bus.output_RegDst   = regdst_q;
        state_d             = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.output_ALUSrcA = 1'b1;
        bus.output_ALUSrcB = SRCB_IMM;
        state_d            = (bus.input_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.output_MemRead = 1'b1;
        bus.output_IorD    = 1'b1;
        if (bus.input_mem_ready) state_d = S_MEM_WB;
        else if (wait_expired)   state_d = S_HALT;
      end
      S_MEM_WB: begin
        bus.output_RegWrite = 1'b1;
        bus.output_MemtoReg = 1'b1;
        state_d             = S_FETCH;
      end
      S_MEM_WR: begin
        bus.output_MemWrite = 1'b1;
        bus.output_IorD     = 1'b1;
        if (bus.input_mem_ready) state_d = S_FETCH;
        else if (wait_expired)   state_d = S_HALT;
      end
      S_BRANCH: begin
        bus.output_ALUSrcA = 1'b1;
        bus.output_ALUOp   = ALU_SUB;
        bus.output_PCSrc   = 2'b01;
        bus.output_PCWrite = (bus.input_opcode == OP_BEQ) ? bus.input_Zero : bus.input_negative;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        bus.output_PCSrc   = 2'b10;
        bus.output_PCWrite = 1'b1;
        state_d            = S_FETCH;
      end
      S_HALT:  bus.output_halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a directed vector table, a per-instruction
// expected-cycle model driven with random instructions, and hand-written reset/timeout/wrap sequences.
module tb_multicycle_control;
  localparam int CNT_W        = 8;
  localparam int MEM_WAIT_MAX = 4;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4, OP_LW = 4'd5, OP_SW = 4'd6, OP_BEQ = 4'd7;
  localparam logic [3:0] OP_BLT = 4'd8, OP_JMP = 4'd9, OP_HALT = 4'd15;

  typedef struct packed {
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
    logic       halted;
  } ctl_t;

  typedef struct {
    logic ready;
    ctl_t exp;
  } cyc_t;

  typedef struct {
    logic [3:0] opcode;
    logic       zero;
    logic       neg;
    int         mem_wait;
    int         exp_cycles;
    int         exp_retire;
    logic       exp_pcw;
    int         exp_mem_cycles;
    int         exp_illegal;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_retired = '0;
  vec_t             vecs [16];

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control #(.CNT_W(CNT_W), .MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ctl_t actual();
    ctl_t a;
    a.srca     = bus.output_ALUSrcA;
    a.srcb     = bus.output_ALUSrcB;
    a.aluop    = bus.output_ALUOp;
    a.pcwrite  = bus.output_PCWrite;
    a.pcsrc    = bus.output_PCSrc;
    a.iord     = bus.output_IorD;
    a.memread  = bus.output_MemRead;
    a.memwrite = bus.output_MemWrite;
    a.irwrite  = bus.output_IRWrite;
    a.regwrite = bus.output_RegWrite;
    a.regdst   = bus.output_RegDst;
    a.memtoreg = bus.output_MemtoReg;
    a.illegal  = bus.output_illegal;
    a.halted   = bus.output_halted;
    return a;
  endfunction

  // Expected control word of each phase, straight from the instruction-phase table.
  function automatic ctl_t fetch_c(input logic pcw);
    ctl_t e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.srcb = 2'b01; e.pcwrite = pcw; return e;
  endfunction
  function automatic ctl_t decode_c(input logic ill);
    ctl_t e = '0; e.srcb = 2'b11; e.illegal = ill; return e;
  endfunction
  function automatic ctl_t exec_r_c(input logic [2:0] op);
    ctl_t e = '0; e.srca = 1'b1; e.aluop = op; return e;
  endfunction
  function automatic ctl_t imm_c();
    ctl_t e = '0; e.srca = 1'b1; e.srcb = 2'b10; return e;
  endfunction
  function automatic ctl_t wb_c(input logic rd, input logic mdr);
    ctl_t e = '0; e.regwrite = 1'b1; e.regdst = rd; e.memtoreg = mdr; return e;
  endfunction
  function automatic ctl_t mem_c(input logic wr);
    ctl_t e = '0; e.iord = 1'b1; e.memread = !wr; e.memwrite = wr; return e;
  endfunction
  function automatic ctl_t branch_c(input logic pcw);
    ctl_t e = '0; e.srca = 1'b1; e.aluop = 3'b001; e.pcsrc = 2'b01; e.pcwrite = pcw; return e;
  endfunction
  function automatic ctl_t jump_c();
    ctl_t e = '0; e.pcsrc = 2'b10; e.pcwrite = 1'b1; return e;
  endfunction
  function automatic ctl_t halt_c();
    ctl_t e = '0; e.halted = 1'b1; return e;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Builds the cycle-by-cycle expectation of one instruction, then plays it against the DUT.
  // Entered anywhere after the negedge of the cycle preceding the instruction's first FETCH cycle.
  task automatic run_instr(input logic [3:0] op, input logic z, input logic n,
                           input int fetch_wait, input int mem_wait);
    cyc_t q[$];
    bit   legal;
    legal = !(op inside {[4'd10:4'd14]});
    for (int i = 0; i < fetch_wait; i++) q.push_back('{1'b0, fetch_c(1'b0)});
    q.push_back('{1'b1, fetch_c(1'b1)});
    q.push_back('{rnd_bit(), decode_c(!legal)});
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        q.push_back('{rnd_bit(), exec_r_c(op[2:0])});
        q.push_back('{rnd_bit(), wb_c(1'b1, 1'b0)});
      end
      OP_ADDI: begin
        q.push_back('{rnd_bit(), imm_c()});
        q.push_back('{rnd_bit(), wb_c(1'b0, 1'b0)});
      end
      OP_LW, OP_SW: begin
        q.push_back('{rnd_bit(), imm_c()});
        for (int i = 0; i < mem_wait; i++) q.push_back('{1'b0, mem_c(op == OP_SW)});
        q.push_back('{1'b1, mem_c(op == OP_SW)});
        if (op == OP_LW) q.push_back('{rnd_bit(), wb_c(1'b0, 1'b1)});
      end
      OP_BEQ:  q.push_back('{rnd_bit(), branch_c(z)});
      OP_BLT:  q.push_back('{rnd_bit(), branch_c(n)});
      OP_JMP:  q.push_back('{rnd_bit(), jump_c()});
      OP_HALT: for (int i = 0; i < 3; i++) q.push_back('{rnd_bit(), halt_c()});
      default: ;
    endcase
    foreach (q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        bus.input_opcode   = op;
        bus.input_Zero     = z;
        bus.input_negative = n;
      end
      bus.input_mem_ready = q[i].ready;
      #1;
      if (i == 0) check("retired_count", 64'(bus.output_retired), 64'(exp_retired));
      check($sformatf("ctl_op%0h_cyc%0d", op, i), 64'(actual()), 64'(q[i].exp));
    end
    if (legal && op != OP_HALT) exp_retired = exp_retired + 1'b1;
  endtask

  // Runs one table vector, answering memory accesses reactively, and measures length and strobes.
  task automatic run_vec(input vec_t v, input int idx);
    int   cycles = 0;
    int   low = 0;
    int   mem_cyc = 0;
    int   ill_cyc = 0;
    logic pcw = 1'b0;
    bit   done = 1'b0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      if (cycles == 0) begin
        bus.input_opcode   = v.opcode;
        bus.input_Zero     = v.zero;
        bus.input_negative = v.neg;
      end
      if ((bus.output_MemRead || bus.output_MemWrite) && bus.output_IorD && low < v.mem_wait) begin
        bus.input_mem_ready = 1'b0;
        low++;
      end else begin
        bus.input_mem_ready = 1'b1;
      end
      #1;
      if (cycles == 0) check($sformatf("vec%0d_retired", idx), 64'(bus.output_retired), 64'(exp_retired));
      cycles++;
      if (bus.output_IorD)                          mem_cyc++;
      if (bus.output_illegal)                       ill_cyc++;
      if (bus.output_PCWrite && !bus.output_IRWrite) pcw = 1'b1;
      done = bus.output_RegWrite || (bus.output_MemWrite && bus.input_mem_ready) ||
             (bus.output_PCSrc != 2'b00) || bus.output_illegal;
    end
    check($sformatf("vec%0d_cycles", idx), 64'(cycles), 64'(v.exp_cycles));
    check($sformatf("vec%0d_pcwrite", idx), 64'(pcw), 64'(v.exp_pcw));
    check($sformatf("vec%0d_mem_cycles", idx), 64'(mem_cyc), 64'(v.exp_mem_cycles));
    check($sformatf("vec%0d_illegal", idx), 64'(ill_cyc), 64'(v.exp_illegal));
    exp_retired = exp_retired + CNT_W'(v.exp_retire);
  endtask

  initial begin
    logic [3:0] op;
    //              opcode  Z     N     wait cyc ret pcw   mem ill
    vecs[0]  = '{OP_ADD,  1'b0, 1'b0, 0, 4, 1, 1'b0, 0, 0};
    vecs[1]  = '{OP_SUB,  1'b0, 1'b0, 0, 4, 1, 1'b0, 0, 0};
    vecs[2]  = '{OP_AND,  1'b1, 1'b1, 0, 4, 1, 1'b0, 0, 0};
    vecs[3]  = '{OP_OR,   1'b0, 1'b0, 0, 4, 1, 1'b0, 0, 0};
    vecs[4]  = '{OP_ADDI, 1'b0, 1'b0, 0, 4, 1, 1'b0, 0, 0};
    vecs[5]  = '{OP_LW,   1'b0, 1'b0, 0, 5, 1, 1'b0, 1, 0};
    vecs[6]  = '{OP_LW,   1'b0, 1'b0, 3, 8, 1, 1'b0, 4, 0};
    vecs[7]  = '{OP_SW,   1'b0, 1'b0, 0, 4, 1, 1'b0, 1, 0};
    vecs[8]  = '{OP_SW,   1'b0, 1'b0, 2, 6, 1, 1'b0, 3, 0};
    vecs[9]  = '{OP_BEQ,  1'b1, 1'b0, 0, 3, 1, 1'b1, 0, 0};
    vecs[10] = '{OP_BEQ,  1'b0, 1'b1, 0, 3, 1, 1'b0, 0, 0};
    vecs[11] = '{OP_BLT,  1'b0, 1'b1, 0, 3, 1, 1'b1, 0, 0};
    vecs[12] = '{OP_BLT,  1'b1, 1'b0, 0, 3, 1, 1'b0, 0, 0};
    vecs[13] = '{OP_JMP,  1'b0, 1'b0, 0, 3, 1, 1'b1, 0, 0};
    vecs[14] = '{4'hA,    1'b0, 1'b0, 0, 2, 0, 1'b0, 0, 1};
    vecs[15] = '{4'hE,    1'b0, 1'b0, 0, 2, 0, 1'b0, 0, 1};

    reset               = 1'b0;
    bus.input_opcode    = 4'h0;
    bus.input_Zero      = 1'b0;
    bus.input_negative  = 1'b0;
    bus.input_mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctl", 64'(actual()), 64'd0);
    check("reset_retired", 64'(bus.output_retired), 64'd0);
    check("reset_fault", 64'(bus.output_fault), 64'd0);
    reset = 1'b1;
    #1;
    check("idle_ctl", 64'(actual()), 64'd0);

    // First instruction with memory always ready, then a fetch answered on the last allowed cycle.
    run_instr(OP_ADD, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SUB, 1'b0, 1'b0, MEM_WAIT_MAX - 1, 0);
    check("no_fault_at_limit", 64'(bus.output_fault), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, rnd_bit(), rnd_bit(), int'($urandom_range(0, MEM_WAIT_MAX - 1)),
                int'($urandom_range(0, MEM_WAIT_MAX - 1)));
    end
    check("random_no_fault", 64'(bus.output_fault), 64'd0);

    // Drive the counter to all-ones and across the wrap.
    while (exp_retired != '1) run_instr(OP_JMP, 1'b0, 1'b0, 0, 0);
    run_instr(OP_JMP, 1'b0, 1'b0, 0, 0);

    // Store stalled in MEM_WR, aborted by reset in the middle of a cycle.
    @(negedge clk);
    bus.input_opcode    = OP_SW;
    bus.input_mem_ready = 1'b1;
    #1;
    check("retired_wrap", 64'(bus.output_retired), 64'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.input_mem_ready = 1'b0;
    #1;
    check("sw_memwrite", 64'(bus.output_MemWrite), 64'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ctl", 64'(actual()), 64'd0);
    check("abort_retired", 64'(bus.output_retired), 64'd0);
    check("abort_fault", 64'(bus.output_fault), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_idle", 64'(actual()), 64'd0);

    // Fetch never answered: fault and halt after MEM_WAIT_MAX waiting cycles.
    for (int k = 0; k < MEM_WAIT_MAX; k++) begin
      @(negedge clk);
      bus.input_mem_ready = 1'b0;
      #1;
      check($sformatf("timeout_fetch%0d", k), 64'(actual()), 64'(fetch_c(1'b0)));
      check($sformatf("timeout_nofault%0d", k), 64'(bus.output_fault), 64'd0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.input_mem_ready = 1'b1;
      #1;
      check($sformatf("timeout_halt%0d", k), 64'(actual()), 64'(halt_c()));
      check($sformatf("timeout_fault%0d", k), 64'(bus.output_fault), 64'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    check("fault_cleared", 64'(bus.output_fault), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_retired = '0;

    run_instr(OP_HALT, 1'b0, 1'b0, 0, 0);
    check("halt_opcode_fault", 64'(bus.output_fault), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
